nist_run_sequencer: RTL

Run controller for the on-chip entropy test path: sequences the ALFSR noise source, its LFSR configurator and the NIST SP 800-22 checker through a programmable number of test runs. Each run resets the source, advances the configurator, discards warm-up bits, evaluates a fixed bit window and tallies the four checker error flags into saturating per-test fail counters. It sits between the top-level pins or host registers and the existing `alfsr` and `NIST_SP_800_22` instances, and drives their clock-enable-style controls and resets.

---
 rtl/nist_seq_pkg.sv | 35 +++
 rtl/nist_phase_timer.sv | 41 ++++
 rtl/nist_run_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nist_seq_pkg.sv
// Shared types and constants for the entropy-test run sequencer.
// Holds the FSM state encoding, default phase lengths and checker test indices.
package nist_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARST = 3'd1,
    S_STEP = 3'd2,
    S_WARM = 3'd3,
    S_TEST = 3'd4,
    S_EVAL = 3'd5,
    S_DONE = 3'd6
  } seq_state_e;

  localparam int unsigned DEF_RST_CYC = 32'd4;
  localparam int unsigned DEF_WARMUP  = 32'd64;
  localparam int unsigned DEF_WINDOW  = 32'd128;

  // Bit positions of error1..error4 in err_in and counter slots in fail_cnt.
  localparam int unsigned TEST_E1 = 32'd0;
  localparam int unsigned TEST_E2 = 32'd1;
  localparam int unsigned TEST_E3 = 32'd2;
  localparam int unsigned TEST_E4 = 32'd3;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b; else m = m;
    if (c > m) m = c; else m = m;
    if (d > m) m = d; else m = m;
    return m;
  endfunction

endpackage

// File: rtl/nist_phase_timer.sv
// Loadable down-counter shared by every timed phase of the run sequencer.
// Holds at zero once expired; also exposes the LSB of its next value.
module nist_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o,
  output logic         odd_next_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign zero_o     = (cnt_q == '0);
  assign odd_next_o = cnt_d[0];

  // Next count: load wins, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nist_run_sequencer.sv
// Campaign controller: per run resets the ALFSR, steps the configurator, warms up,
// opens a checker window and folds the sticky error flags into saturating counters.
module nist_run_sequencer
  import nist_seq_pkg::*;
#(
  parameter int unsigned RST_CYC = DEF_RST_CYC,
  parameter int unsigned WARMUP  = DEF_WARMUP,
  parameter int unsigned WINDOW  = DEF_WINDOW,
  parameter int unsigned STEP_W  = 32'd4,
  parameter int unsigned RUNS_W  = 32'd8,
  parameter int unsigned CNT_W   = 32'd8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [RUNS_W-1:0]    n_runs,
  input  logic [STEP_W-1:0]    cfg_steps,
  input  logic [3:0]           err_in,
  output logic                 lfsr_clk,
  output logic                 alfsr_rst_n,
  output logic                 nist_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic [RUNS_W-1:0]    run_cnt,
  output logic [4*CNT_W-1:0]   fail_cnt,
  output logic                 any_fail
);

  localparam int unsigned TMR_MAX = max4(RST_CYC, WARMUP, WINDOW, 32'd2 << STEP_W);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 32'd1);

  seq_state_e state_q, state_d;
  logic [RUNS_W-1:0]  n_runs_q, n_runs_d;
  logic [STEP_W-1:0]  steps_q, steps_d;
  logic [RUNS_W-1:0]  run_cnt_q, run_cnt_d;
  logic [4*CNT_W-1:0] fail_q, fail_d;
  logic [3:0]         err_lat_q, err_lat_d;
  logic               lfsr_clk_q, alfsr_rst_n_q, nist_rst_n_q, busy_q, done_q, any_fail_q;
  logic               lfsr_clk_d, alfsr_rst_n_d, nist_rst_n_d, busy_d, done_d;

  logic               tmr_load_s;
  logic [TMR_W-1:0]   tmr_val_s;
  logic               tmr_zero_s;
  logic               tmr_odd_next_s;
  logic               in_busy_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + CNT_W'(1);
  endfunction

  nist_phase_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_s),
    .value_i    (tmr_val_s),
    .zero_o     (tmr_zero_s),
    .odd_next_o (tmr_odd_next_s)
  );

  assign in_busy_s = (state_q == S_ARST) || (state_q == S_STEP) || (state_q == S_WARM) ||
                     (state_q == S_TEST) || (state_q == S_EVAL);

  // Next-state, timer load and campaign bookkeeping.
  always_comb begin
    state_d    = state_q;
    n_runs_d   = n_runs_q;
    steps_d    = steps_q;
    run_cnt_d  = run_cnt_q;
    fail_d     = fail_q;
    err_lat_d  = err_lat_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_runs_d  = n_runs;
          steps_d   = cfg_steps;
          run_cnt_d = '0;
          fail_d    = '0;
          if (n_runs == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ARST;
            tmr_load_s = 1'b1;
            tmr_val_s  = TMR_W'(RST_CYC - 32'd1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARST: begin
        if (!tmr_zero_s) begin
          state_d = S_ARST;
        end else if (steps_q == '0) begin
          state_d    = S_WARM;
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(WARMUP - 32'd1);
        end else begin
          // One count per half-period; odd counts are the high halves.
          state_d    = S_STEP;
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'({steps_q, 1'b0}) - TMR_W'(1);
        end
      end
      S_STEP: begin
        if (tmr_zero_s) begin
          state_d    = S_WARM;
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(WARMUP - 32'd1);
        end else begin
          state_d = S_STEP;
        end
      end
      S_WARM: begin
        if (tmr_zero_s) begin
          state_d    = S_TEST;
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(WINDOW - 32'd1);
          err_lat_d  = 4'b0000;
        end else begin
          state_d = S_WARM;
        end
      end
      S_TEST: begin
        err_lat_d = err_lat_q | err_in;
        if (tmr_zero_s) begin
          state_d = S_EVAL;
        end else begin
          state_d = S_TEST;
        end
      end
      S_EVAL: begin
        if (err_lat_q[TEST_E1]) fail_d[TEST_E1*CNT_W +: CNT_W] = sat_inc(fail_q[TEST_E1*CNT_W +: CNT_W]);
        else                    fail_d[TEST_E1*CNT_W +: CNT_W] = fail_q[TEST_E1*CNT_W +: CNT_W];
        if (err_lat_q[TEST_E2]) fail_d[TEST_E2*CNT_W +: CNT_W] = sat_inc(fail_q[TEST_E2*CNT_W +: CNT_W]);
        else                    fail_d[TEST_E2*CNT_W +: CNT_W] = fail_q[TEST_E2*CNT_W +: CNT_W];
        if (err_lat_q[TEST_E3]) fail_d[TEST_E3*CNT_W +: CNT_W] = sat_inc(fail_q[TEST_E3*CNT_W +: CNT_W]);
        else                    fail_d[TEST_E3*CNT_W +: CNT_W] = fail_q[TEST_E3*CNT_W +: CNT_W];
        if (err_lat_q[TEST_E4]) fail_d[TEST_E4*CNT_W +: CNT_W] = sat_inc(fail_q[TEST_E4*CNT_W +: CNT_W]);
        else                    fail_d[TEST_E4*CNT_W +: CNT_W] = fail_q[TEST_E4*CNT_W +: CNT_W];
        run_cnt_d = run_cnt_q + RUNS_W'(1);
        if (run_cnt_d == n_runs_q) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_ARST;
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(RST_CYC - 32'd1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort discards the run in progress, including an EVAL in flight.
    if (abort && in_busy_s) begin
      state_d    = S_IDLE;
      run_cnt_d  = run_cnt_q;
      fail_d     = fail_q;
      err_lat_d  = err_lat_q;
      tmr_load_s = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    busy_d        = 1'b0;
    done_d        = 1'b0;
    alfsr_rst_n_d = 1'b0;
    nist_rst_n_d  = 1'b0;
    lfsr_clk_d    = 1'b0;
    case (state_d)
      S_ARST: begin
        busy_d = 1'b1;
      end
      S_STEP: begin
        busy_d     = 1'b1;
        lfsr_clk_d = tmr_odd_next_s;
      end
      S_WARM: begin
        busy_d        = 1'b1;
        alfsr_rst_n_d = 1'b1;
      end
      S_TEST, S_EVAL: begin
        busy_d        = 1'b1;
        alfsr_rst_n_d = 1'b1;
        nist_rst_n_d  = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, campaign registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      n_runs_q      <= '0;
      steps_q       <= '0;
      run_cnt_q     <= '0;
      fail_q        <= '0;
      err_lat_q     <= 4'b0000;
      lfsr_clk_q    <= 1'b0;
      alfsr_rst_n_q <= 1'b0;
      nist_rst_n_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      any_fail_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_runs_q      <= n_runs_d;
      steps_q       <= steps_d;
      run_cnt_q     <= run_cnt_d;
      fail_q        <= fail_d;
      err_lat_q     <= err_lat_d;
      lfsr_clk_q    <= lfsr_clk_d;
      alfsr_rst_n_q <= alfsr_rst_n_d;
      nist_rst_n_q  <= nist_rst_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      any_fail_q    <= |fail_d;
    end
  end

  assign lfsr_clk    = lfsr_clk_q;
  assign alfsr_rst_n = alfsr_rst_n_q;
  assign nist_rst_n  = nist_rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign run_cnt     = run_cnt_q;
  assign fail_cnt    = fail_q;
  assign any_fail    = any_fail_q;

endmodule
